uart_tx_io: RTL
===============

// Module: uart_tx_io
// PURPOSE
//  Memory-mapped UART transmitter: the PC-bound counterpart of the UART program-load receive path.
//  CPU stores bytes through the MemOrIO I/O window; the block buffers them in a FIFO and serialises 8N1
//  (optionally 8E1) frames on tx, LSB first. Status is readable over the same I/O bus. Sits beside ledDriver/Switch.
// PARAMETERS
//  CLK_FREQ_HZ  23_000_000  frequency of clk (cpu_clk)
//  BAUD         115_200     line rate; DIV = CLK_FREQ_HZ/BAUD (integer, truncated), DIV >= 4 required
//  FIFO_DEPTH   8           transmit buffer entries, power of two, >= 2
// PORTS
//  clk          in   1   cpu clock; all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  uarttxcs     in   1   chip select (UartCtrl from MemOrIO)
//  uarttxwrite  in   1   I/O write strobe (ioWrite), qualified by cs
//  uarttxread   in   1   I/O read strobe (ioRead), qualified by cs
//  uarttxaddr   in   2   offset: 2'b00 DATA, 2'b10 STATUS
//  uarttxwdata  in   8   write byte
//  uarttxrdata  out  16  read data, combinational from registered state
//  tx           out  1   serial line, idle high, registered
// BEHAVIOUR
//  Reset: tx=1, state IDLE, FIFO empty, overflow=0, baud count=0, uarttxrdata=0. Reset mid-frame aborts at once.
//  Write DATA (cs&write&addr==00): push uarttxwdata if not full; if full, byte dropped, overflow<=1 (sticky).
//  Write STATUS (addr==10): any value clears overflow. Writes to other offsets ignored.
//  Read STATUS: {13'b0, overflow, full, busy}; busy = (state!=IDLE) | !empty. Read DATA/others -> 16'h0000.
//  uarttxrdata is 0 whenever !(cs&read). Reads have no side effects.
//  FIFO: push and pop on the same edge are both honoured, including when full (pop frees the slot).
//   No bypass: a byte pushed at edge k is first poppable at edge k+1.
//  FSM: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> IDLE/START.
//   IDLE: if !empty, pop into shift reg, enter START, tx<=0, baud count<=0 on the same edge.
//   Each bit lasts exactly DIV clocks; bit advances when count==DIV-1 (count then wraps to 0).
//   DATA: tx = shift[0], shift right each bit, bit index 0..7.
//   STOP: tx=1 for DIV clocks; at its end pop next byte directly into START if !empty (no idle gap), else IDLE.
//  Latency: write to empty idle FIFO at edge k -> tx falls after edge k+1; frame = 10*DIV clocks (11*DIV with parity).
//  Simultaneous DATA write and STATUS clear impossible (single address); overflow set and clear never coincide.
// CONFIGURATION
//  `UART_TX_PARITY_EN defined: PARITY state inserted after bit 7, tx = ^data (even parity), frame 11*DIV.
//  Not defined: no PARITY state, 8N1, frame 10*DIV. Status layout unchanged in both builds.
// STRUCTURE
//  Shared package/header uart_pkg: FSM state encodings, offsets ADDR_DATA=2'b00/ADDR_STATUS=2'b10, status bit positions.
//  Sub-module uart_tx_fifo (DEPTH, WIDTH=8): push/pop/full/empty, pointers with extra wrap bit.
//  Top holds baud counter, FSM, shift register, bus decode.
// TESTING (CLK_FREQ_HZ=1_000_000, BAUD=100_000 -> DIV=10)
//  Reset then idle 50 clks -> tx=1, status read = 16'h0000.
//  Write 8'h55 at edge k -> tx=0 from k+1 for 10 clks, then 1,0,1,0,1,0,1,0 each 10 clks, stop 1; busy clears at k+101.
//  Write 10 bytes back-to-back from idle -> 1st popped, 8 buffered, 10th dropped; status = 16'h0007.
//  Write STATUS 0 after previous -> overflow=0, full/busy unchanged; all 9 accepted bytes sent in order, no gaps.
//  Assert rst mid-DATA of byte 8'hA3 with 3 queued -> tx=1 same cycle, status 0, nothing resumes after release.
//  `UART_TX_PARITY_EN: write 8'h07 -> parity bit 1, frame 110 clks; write 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - tx_state_e : transmit FSM state encoding
//   - ADDR_*     : I/O window offsets (DATA, STATUS)
//   - STAT_*     : bit positions inside the STATUS read word
//   - status_word: packs the STATUS read word from its three flags
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b10;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                                input logic busy);
        logic [15:0] w;
        w            = 16'h0000;
        w[STAT_OVF]  = ovf;
        w[STAT_FULL] = full;
        w[STAT_BUSY] = busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_io_if.sv
// I/O bus bundle between the MemOrIO decode (master) and uart_tx_io (slave).
//   uarttxcs     chip select
//   uarttxwrite  write strobe, qualified by cs
//   uarttxread   read strobe, qualified by cs
//   uarttxaddr   2-bit offset (DATA / STATUS)
//   uarttxwdata  write byte
//   uarttxrdata  16-bit read data from the slave
//   dbg_state    current transmit FSM state, for observation only
//
// Handshake: there is no valid/ready pair. A transfer happens on every rising
// clk edge where uarttxcs is high together with uarttxwrite (write) or
// uarttxread (read); the slave never stalls. Read data is combinational and
// meaningful only while cs & read are high, 16'h0000 otherwise.
interface uart_tx_io_if;
    import uart_pkg::*;

    logic        uarttxcs;
    logic        uarttxwrite;
    logic        uarttxread;
    logic [1:0]  uarttxaddr;
    logic [7:0]  uarttxwdata;
    logic [15:0] uarttxrdata;
    tx_state_e   dbg_state;

    modport master (
        output uarttxcs, uarttxwrite, uarttxread, uarttxaddr, uarttxwdata,
        input  uarttxrdata, dbg_state
    );

    modport slave (
        input  uarttxcs, uarttxwrite, uarttxread, uarttxaddr, uarttxwdata,
        output uarttxrdata, dbg_state
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer.
//   clk, rst : clock, asynchronous active-high reset (empties the buffer)
//   push     : write request; honoured when not full, or when full and popping
//   pop      : read request; honoured when not empty
//   wdata    : byte to store
//   rdata    : oldest stored byte (valid when !empty)
//   full     : DEPTH entries stored
//   empty    : nothing stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// There is no bypass: a byte pushed on one edge is visible on rdata after it.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop on the same edge frees the slot, so a push into a full buffer is
    // still accepted when it coincides with a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN defined).
//   clk  : cpu clock
//   rst  : asynchronous active-high reset; aborts any frame immediately
//   bus  : uart_tx_io_if.slave - chip select, read/write strobes, offset,
//          write byte, read data, FSM state for observation
//   tx   : serial line, idle high, registered
// DATA offset write queues a byte (dropped with sticky overflow when full).
// STATUS offset write clears overflow; STATUS read = {13'b0, ovf, full, busy}.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit after
// bit 7 (frame becomes 11 bit times instead of 10).
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 23_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_io_if.slave   bus,
    output logic          tx
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    tx_state_e        state_q, state_d;
    logic             tx_q, tx_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       push_req;
    logic       clr_ovf;
    logic       bit_end;
    logic       busy;

    assign push_req = bus.uarttxcs && bus.uarttxwrite && (bus.uarttxaddr == ADDR_DATA);
    assign clr_ovf  = bus.uarttxcs && bus.uarttxwrite && (bus.uarttxaddr == ADDR_STATUS);
    assign bit_end  = (cnt_q == CNT_LAST);
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (bus.uarttxwdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = bit_end ? '0 : cnt_q + CNT_W'(1);
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                    shift_d  = fifo_rdata;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                end
            end
            // The shift register is pre-shifted as each bit is launched, so
            // shift_q[0] always holds the next bit to put on the line.
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            // Chain straight into the next start bit when more data waits,
            // so back-to-back frames have no idle gap.
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rdata;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase

        // A full-buffer write is dropped only if no pop frees a slot this edge.
        if (push_req && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx            = tx_q;
    assign bus.dbg_state = state_q;
    assign bus.uarttxrdata = (bus.uarttxcs && bus.uarttxread && (bus.uarttxaddr == ADDR_STATUS))
                             ? status_word(overflow_q, fifo_full, busy)
                             : 16'h0000;

endmodule
